// File: rtl/johnson_pkg.sv
// Shared types, constants and helper functions for the Johnson sequencer.
// Code helpers work on a fixed maximum-width vector; callers slice or extend
// to their own register width.
package johnson_pkg;

  // Widest Johnson register the helper functions can describe.
  localparam int unsigned JOHNSON_MAX_W = 64;

  // Direction encoding of the dir input.
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // What the sequencer does on the next enabled edge, in priority order.
  typedef enum logic [2:0] {
    ACT_HOLD    = 3'd0,
    ACT_LOAD    = 3'd1,
    ACT_RECOVER = 3'd2,
    ACT_FWD     = 3'd3,
    ACT_REV     = 3'd4
  } step_act_e;

  // Width of a phase index for a register of w bits (2*w phases).
  function automatic int phase_width(input int w);
    return $clog2(2 * w);
  endfunction

  // Mask with the lowest n bits set.
  function automatic logic [JOHNSON_MAX_W-1:0] low_mask(input int unsigned n);
    if (n >= JOHNSON_MAX_W) begin
      return '1;
    end
    return (JOHNSON_MAX_W'(1) << n) - JOHNSON_MAX_W'(1);
  endfunction

  // Johnson code for a phase: phases 0..w fill ones from the bottom,
  // phases w+1..2w-1 then clear them from the bottom again.
  function automatic logic [JOHNSON_MAX_W-1:0] phase_to_code(input int unsigned phase,
                                                             input int unsigned w);
    logic [JOHNSON_MAX_W-1:0] code;
    if (phase <= w) begin
      code = low_mask(phase);
    end else begin
      code = low_mask(w) & ~low_mask(phase - w);
    end
    return code;
  endfunction

  // A legal code is either a run of ones from the bottom (0..01..1) or, within
  // the register width, a run of ones from the top (1..10..0). Each shape is
  // detected by checking that adding one clears every set bit.
  function automatic logic code_is_legal(input logic [JOHNSON_MAX_W-1:0] code,
                                         input int unsigned w);
    logic [JOHNSON_MAX_W-1:0] wmask;
    logic [JOHNSON_MAX_W-1:0] inv;
    wmask = low_mask(w);
    inv   = ~code & wmask;
    if ((code & ~wmask) != '0) begin
      return 1'b0;
    end
    return ((code & (code + JOHNSON_MAX_W'(1))) == '0) ||
           ((inv & (inv + JOHNSON_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/johnson_seq_core_if.sv
// Control/status bundle between a controller and johnson_seq_core.
// Optional macro JOHNSON_ONEHOT_EN adds the registered onehot phase output.
interface johnson_seq_core_if #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 16
);
  import johnson_pkg::*;

  localparam int PHASE_W = phase_width(WIDTH);

  logic               ena;
  logic               run;
  logic               dir;
  logic [PRESC_W-1:0] presc_div;
  logic               load;
  logic [PHASE_W-1:0] load_phase;
  logic [WIDTH-1:0]   q;
  logic [PHASE_W-1:0] phase;
  logic               step_pulse;
  logic               wrap;
  logic               illegal_seen;
`ifdef JOHNSON_ONEHOT_EN
  logic [2*WIDTH-1:0] onehot;
`endif

  // Controller side: drives commands, observes sequencer state.
  modport master (
    output ena, run, dir, presc_div, load, load_phase,
`ifdef JOHNSON_ONEHOT_EN
    input  onehot,
`endif
    input  q, phase, step_pulse, wrap, illegal_seen
  );

  // Sequencer side.
  modport slave (
    input  ena, run, dir, presc_div, load, load_phase,
`ifdef JOHNSON_ONEHOT_EN
    output onehot,
`endif
    output q, phase, step_pulse, wrap, illegal_seen
  );

endinterface

// File: rtl/johnson_prescaler.sv
// Step prescaler: produces a one-cycle tick every div+1 enabled run cycles.
// clr restarts the count (used for phase load and illegal-state recovery).
module johnson_prescaler
  import johnson_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               run,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;
  logic               due;

  // The >= compare means a divider lowered below the running count fires on
  // the next enabled cycle instead of wrapping all the way round.
  assign due  = (cnt >= div);
  assign tick = ena & run & ~clr & due;

  // Count enabled run cycles; hold when disabled or not running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (clr) begin
        cnt <= '0;
      end else if (run) begin
        cnt <= due ? '0 : cnt + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/johnson_seq_core.sv
// Johnson (twisted-ring) sequencer with prescaled stepping, direction control,
// phase load and illegal-state self-recovery. All outputs are registered.
// Optional macro JOHNSON_ONEHOT_EN adds a registered onehot phase output.
module johnson_seq_core
  import johnson_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  johnson_seq_core_if.slave bus
);

  localparam int PHASE_W = phase_width(WIDTH);
  localparam int PHASES  = 2 * WIDTH;
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES - 1);

  logic [WIDTH-1:0]   q_r,       q_nxt;
  logic [PHASE_W-1:0] phase_r,   phase_nxt;
  logic               step_r,    step_nxt;
  logic               wrap_r,    wrap_nxt;
  logic               illegal_r, illegal_nxt;

  logic               tick;
  logic               illegal_now;
  logic [PHASE_W-1:0] load_phase_eff;
  logic [WIDTH-1:0]   load_code;
  logic [WIDTH-1:0]   q_fwd;
  logic [WIDTH-1:0]   q_rev;
  logic [PHASE_W-1:0] phase_fwd;
  logic [PHASE_W-1:0] phase_rev;
  step_act_e          act;

  assign illegal_now = ~code_is_legal(JOHNSON_MAX_W'(q_r), 32'(WIDTH));

  // Out-of-range load indices fall back to phase 0.
  assign load_phase_eff = (32'(bus.load_phase) >= 32'(PHASES)) ? '0 : bus.load_phase;
  assign load_code      = WIDTH'(phase_to_code(32'(load_phase_eff), 32'(WIDTH)));

  assign q_fwd     = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
  assign q_rev     = {~q_r[0], q_r[WIDTH-1:1]};
  assign phase_fwd = (phase_r == LAST_PHASE) ? '0 : phase_r + PHASE_W'(1);
  assign phase_rev = (phase_r == '0) ? LAST_PHASE : phase_r - PHASE_W'(1);

  johnson_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (bus.ena),
    .run   (bus.run),
    .clr   (bus.load | illegal_now),
    .div   (bus.presc_div),
    .tick  (tick)
  );

  // Pick this cycle's action: load beats recovery, recovery beats stepping.
  always_comb begin
    act = ACT_HOLD;
    if (bus.ena) begin
      if (bus.load) begin
        act = ACT_LOAD;
      end else if (illegal_now) begin
        act = ACT_RECOVER;
      end else if (tick) begin
        act = (bus.dir == DIR_FWD) ? ACT_FWD : ACT_REV;
      end
    end
  end

  // Next register values for the chosen action; pulses default low.
  always_comb begin
    q_nxt       = q_r;
    phase_nxt   = phase_r;
    step_nxt    = 1'b0;
    wrap_nxt    = 1'b0;
    illegal_nxt = illegal_r;
    case (act)
      ACT_LOAD: begin
        q_nxt     = load_code;
        phase_nxt = load_phase_eff;
      end
      ACT_RECOVER: begin
        q_nxt       = '0;
        phase_nxt   = '0;
        illegal_nxt = 1'b1;
      end
      ACT_FWD: begin
        q_nxt     = q_fwd;
        phase_nxt = phase_fwd;
        step_nxt  = 1'b1;
        wrap_nxt  = (phase_r == LAST_PHASE);
      end
      ACT_REV: begin
        q_nxt     = q_rev;
        phase_nxt = phase_rev;
        step_nxt  = 1'b1;
        wrap_nxt  = (phase_r == '0);
      end
      default: begin
      end
    endcase
  end

  // Sequencer state and output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r       <= '0;
      phase_r   <= '0;
      step_r    <= 1'b0;
      wrap_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      q_r       <= q_nxt;
      phase_r   <= phase_nxt;
      step_r    <= step_nxt;
      wrap_r    <= wrap_nxt;
      illegal_r <= illegal_nxt;
    end
  end

  assign bus.q            = q_r;
  assign bus.phase        = phase_r;
  assign bus.step_pulse   = step_r;
  assign bus.wrap         = wrap_r;
  assign bus.illegal_seen = illegal_r;

`ifdef JOHNSON_ONEHOT_EN
  logic [PHASES-1:0] onehot_r;

  // Onehot copy of the phase, tracking the same edge as phase_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_r <= PHASES'(1);
    end else begin
      onehot_r <= PHASES'(1) << phase_nxt;
    end
  end

  assign bus.onehot = onehot_r;
`endif

endmodule

// File: tb/tb_johnson_seq_core.sv
// Directed self-checking bench for johnson_seq_core (WIDTH=4 main instance,
// WIDTH=5 instance for out-of-range phase loads). Honours JOHNSON_ONEHOT_EN.
module tb_johnson_seq_core;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  johnson_seq_core_if #(.WIDTH(4), .PRESC_W(8)) bus4 ();
  johnson_seq_core_if #(.WIDTH(5), .PRESC_W(8)) bus5 ();

  johnson_seq_core #(.WIDTH(4), .PRESC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  johnson_seq_core #(.WIDTH(5), .PRESC_W(8)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic       run;
    logic       dir;
    logic [7:0] div;
    logic       load;
    logic [2:0] lp;
    logic [3:0] q;
    logic [2:0] ph;
    logic       step;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic r, input logic d,
                              input logic [7:0] dv, input logic ld, input logic [2:0] lp,
                              input logic [3:0] q, input logic [2:0] ph,
                              input logic st, input logic wr);
    vec_t v;
    v.ena = e; v.run = r; v.dir = d; v.div = dv; v.load = ld; v.lp = lp;
    v.q = q; v.ph = ph; v.step = st; v.wrap = wr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus4.ena        = v.ena;
    bus4.run        = v.run;
    bus4.dir        = v.dir;
    bus4.presc_div  = v.div;
    bus4.load       = v.load;
    bus4.load_phase = v.lp;
  endtask

  task automatic checkMain(input string tag, input logic [3:0] q, input logic [2:0] ph,
                           input logic st, input logic wr);
    checkOutput({tag, " q"},     32'(bus4.q),          32'(q));
    checkOutput({tag, " phase"}, 32'(bus4.phase),      32'(ph));
    checkOutput({tag, " step"},  32'(bus4.step_pulse), 32'(st));
    checkOutput({tag, " wrap"},  32'(bus4.wrap),       32'(wr));
`ifdef JOHNSON_ONEHOT_EN
    checkOutput({tag, " onehot"}, 32'(bus4.onehot), 32'(1) << ph);
`endif
  endtask

  task automatic load5(input logic [3:0] lp, input logic [4:0] q, input logic [3:0] ph);
    @(negedge clk);
    bus5.ena = 1'b1; bus5.load = 1'b1; bus5.load_phase = lp;
    @(posedge clk); #1;
    checkOutput($sformatf("w5 load%0d q", lp),     32'(bus5.q),     32'(q));
    checkOutput($sformatf("w5 load%0d phase", lp), 32'(bus5.phase), 32'(ph));
    checkOutput($sformatf("w5 load%0d step", lp),  32'(bus5.step_pulse), 32'(0));
`ifdef JOHNSON_ONEHOT_EN
    checkOutput($sformatf("w5 load%0d onehot", lp), 32'(bus5.onehot), 32'(1) << ph);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus4.ena = 1'b0; bus4.run = 1'b0; bus4.dir = 1'b0; bus4.presc_div = '0;
    bus4.load = 1'b0; bus4.load_phase = '0;
    bus5.ena = 1'b0; bus5.run = 1'b0; bus5.dir = 1'b0; bus5.presc_div = '0;
    bus5.load = 1'b0; bus5.load_phase = '0;

    // Forward run with presc_div=0, including the 1000->0000 wrap.
    vecs.push_back(mk(1,1,0,0,0,0, 4'b0001,1,1,0));
    vecs.push_back(mk(1,1,0,0,0,0, 4'b0011,2,1,0));
    vecs.push_back(mk(1,1,0,0,0,0, 4'b0111,3,1,0));
    vecs.push_back(mk(1,1,0,0,0,0, 4'b1111,4,1,0));
    vecs.push_back(mk(1,1,0,0,0,0, 4'b1110,5,1,0));
    vecs.push_back(mk(1,1,0,0,0,0, 4'b1100,6,1,0));
    vecs.push_back(mk(1,1,0,0,0,0, 4'b1000,7,1,0));
    vecs.push_back(mk(1,1,0,0,0,0, 4'b0000,0,1,1));
    vecs.push_back(mk(1,1,0,0,0,0, 4'b0001,1,1,0));
    // run low, then ena low: hold without pulses.
    vecs.push_back(mk(1,0,0,0,0,0, 4'b0001,1,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 4'b0001,1,0,0));
    // Reverse, wrapping 0 -> 7, then back to forward.
    vecs.push_back(mk(1,1,1,0,0,0, 4'b0000,0,1,0));
    vecs.push_back(mk(1,1,1,0,0,0, 4'b1000,7,1,1));
    vecs.push_back(mk(1,1,1,0,0,0, 4'b1100,6,1,0));
    vecs.push_back(mk(1,1,0,0,0,0, 4'b1000,7,1,0));
    // Loads while a step is due win and suppress the pulse.
    vecs.push_back(mk(1,1,0,0,1,5, 4'b1110,5,0,0));
    vecs.push_back(mk(1,1,0,0,1,2, 4'b0011,2,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 4'b0111,3,1,0));
    // presc_div=2: step every third enabled cycle, ena gap mid-count.
    vecs.push_back(mk(1,1,0,2,0,0, 4'b0111,3,0,0));
    vecs.push_back(mk(1,1,0,2,0,0, 4'b0111,3,0,0));
    vecs.push_back(mk(1,1,0,2,0,0, 4'b1111,4,1,0));
    vecs.push_back(mk(1,1,0,2,0,0, 4'b1111,4,0,0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,1,0,2,0,0, 4'b1111,4,0,0));
    vecs.push_back(mk(1,1,0,2,0,0, 4'b1111,4,0,0));
    vecs.push_back(mk(1,1,0,2,0,0, 4'b1110,5,1,0));
    // Count to 3 under div=5, then drop div to 1: immediate step.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,1,0,5,0,0, 4'b1110,5,0,0));
    vecs.push_back(mk(1,1,0,1,0,0, 4'b1100,6,1,0));
    vecs.push_back(mk(1,1,0,1,0,0, 4'b1100,6,0,0));
    vecs.push_back(mk(1,1,0,1,0,0, 4'b1000,7,1,0));
    vecs.push_back(mk(0,1,0,1,0,0, 4'b1000,7,0,0));

    // Reset state, checked before any clock edge.
    #3;
    checkMain("reset", 4'b0000, 3'd0, 1'b0, 1'b0);
    checkOutput("reset illegal", 32'(bus4.illegal_seen), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk); #1;
      checkMain($sformatf("v%0d", i), vecs[i].q, vecs[i].ph, vecs[i].step, vecs[i].wrap);
      checkOutput($sformatf("v%0d illegal", i), 32'(bus4.illegal_seen), 32'(0));
    end

    // Plant an illegal code while disabled; it must survive until enabled.
    @(negedge clk);
    bus4.ena = 1'b0;
    force dut.q_r = 4'b0101;
    #1;
    release dut.q_r;
    @(posedge clk); #1;
    checkOutput("illegal held q", 32'(bus4.q), 32'(4'b0101));
    checkOutput("illegal held flag", 32'(bus4.illegal_seen), 32'(0));

    // Recovery happens even with run low.
    @(negedge clk);
    bus4.ena = 1'b1; bus4.run = 1'b0; bus4.load = 1'b0;
    @(posedge clk); #1;
    checkMain("recover", 4'b0000, 3'd0, 1'b0, 1'b0);
    checkOutput("recover flag", 32'(bus4.illegal_seen), 32'(1));

    // Flag is sticky while stepping resumes.
    @(negedge clk);
    bus4.run = 1'b1; bus4.dir = 1'b0; bus4.presc_div = '0;
    @(posedge clk); #1;
    checkMain("post recover", 4'b0001, 3'd1, 1'b1, 1'b0);
    checkOutput("sticky flag", 32'(bus4.illegal_seen), 32'(1));

    // Asynchronous reset mid-cycle clears everything without a clock.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkMain("async reset", 4'b0000, 3'd0, 1'b0, 1'b0);
    checkOutput("async reset flag", 32'(bus4.illegal_seen), 32'(0));
    #1 rst_n = 1'b1;
    bus4.ena = 1'b0;

    // WIDTH=5 instance: in-range, out-of-range and boundary loads.
    load5(4'd7,  5'b11100, 4'd7);
    load5(4'd12, 5'b00000, 4'd0);
    load5(4'd9,  5'b10000, 4'd9);
    load5(4'd10, 5'b00000, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
